avr_spi_bridge: RTL

- Boot-time bridge between the AVR SPI link and NUM_CH serial targets, e.g. SD card, flash or future devices.
- Replaces the combinational SD pass-through: the FPGA is an SPI slave to the AVR, re-clocks every byte through its own SPI master at a programmable rate, and routes it to the selected target.
- Sits in the boot FPGA top level, fclk domain.

---
 rtl/avr_spi_bridge_pkg.sv | 22 ++
 rtl/spi_master_engine.sv | 106 ++++++++++
 rtl/avr_spi_bridge.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/avr_spi_bridge_pkg.sv
// Shared definitions for the AVR SPI bridge:
// command/status field positions and master states.
package avr_spi_bridge_pkg;

  localparam int CMD_CS_BIT = 7;
  localparam int CMD_CH_HI  = 6;
  localparam int CMD_CH_LO  = 4;
  localparam int CMD_DIV_HI = 3;
  localparam int CMD_DIV_LO = 0;

  localparam int ST_OVR_BIT  = 0;
  localparam int ST_BUSY_BIT = 1;

  typedef enum logic [2:0] {
    M_IDLE,
    M_SETUP,
    M_RISE,
    M_FALL,
    M_DONE
  } mstate_e;

endpackage

// File: rtl/spi_master_engine.sv
// Mode-0 SPI master byte engine with a
// programmable SCK half-period of div+1 clocks.
module spi_master_engine
  import avr_spi_bridge_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [7:0]       tx_i,
  input  logic             miso_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       rx_o,
  output logic             sck_o,
  output logic             mosi_o
);

  mstate_e          st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [6:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= M_IDLE;
      cnt_q  <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      rx_q   <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    mosi_d = mosi_q;
    tick   = (cnt_q == div_q);
    unique case (st_q)
      M_IDLE: begin
        if (start_i) begin
          st_d   = M_SETUP;
          cnt_d  = '0;
          div_d  = div_i;
          bit_d  = '0;
          sh_d   = tx_i[6:0];
          mosi_d = tx_i[7];
        end
      end
      // low phases; the last one ends the byte
      M_SETUP, M_FALL: begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        if (tick) begin
          if (bit_q == 4'd8) begin
            st_d = M_DONE;
          end else begin
            st_d = M_RISE;
            rx_d = {rx_q[6:0], miso_i};
          end
        end
      end
      M_RISE: begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        if (tick) begin
          st_d   = M_FALL;
          mosi_d = sh_q[6];
          sh_d   = {sh_q[5:0], 1'b1};
          bit_d  = bit_q + 4'd1;
        end
      end
      M_DONE: st_d = M_IDLE;
      default: st_d = M_IDLE;
    endcase
    sck_d = (st_d == M_RISE);
  end

  assign busy_o = (st_q != M_IDLE);
  assign done_o = (st_q == M_DONE);
  assign rx_o   = rx_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/avr_spi_bridge.sv
// AVR SPI slave re-clocked through a local SPI master to NUM_CH targets.
// Define BRIDGE_STATUS_EN to return the status byte at frame start.
module avr_spi_bridge
  import avr_spi_bridge_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              spics_n,
  input  logic              spick,
  input  logic              spido,
  output logic              spidi,
  output logic              spiint_n,
  output logic [NUM_CH-1:0] ch_cs_n,
  output logic              ch_sck,
  output logic              ch_mosi,
  input  logic [NUM_CH-1:0] ch_miso,
  output logic              act
);

  logic [SYNC_STAGES-1:0] cs_sq, ck_sq, do_sq;
  logic cs_pq, ck_pq;
  logic cs_s, ck_s, do_s;
  logic frm_start, frm_end, ck_rise, ck_fall;
  logic byte_done;
  logic [7:0] byte_w;

  logic [2:0]        bcnt_q, bcnt_d;
  logic [6:0]        rsh_q, rsh_d;
  logic [7:0]        tsh_q, tsh_d;
  logic              spidi_q, spidi_d;
  logic              first_q, first_d;
  logic [2:0]        ch_q, ch_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0] cs_n_q, cs_n_d;
  logic              endp_q, endp_d;
  logic [7:0]        status;

  logic       busy, m_start, m_done, m_miso;
  logic [7:0] m_rx;

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      cs_sq <= '1;
      ck_sq <= '0;
      do_sq <= '0;
      cs_pq <= 1'b1;
      ck_pq <= 1'b0;
    end else begin
      cs_sq <= {cs_sq[SYNC_STAGES-2:0], spics_n};
      ck_sq <= {ck_sq[SYNC_STAGES-2:0], spick};
      do_sq <= {do_sq[SYNC_STAGES-2:0], spido};
      cs_pq <= cs_sq[SYNC_STAGES-1];
      ck_pq <= ck_sq[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sq[SYNC_STAGES-1];
  assign ck_s      = ck_sq[SYNC_STAGES-1];
  assign do_s      = do_sq[SYNC_STAGES-1];
  assign frm_start = cs_pq & ~cs_s;
  assign frm_end   = ~cs_pq & cs_s;
  assign ck_rise   = ~cs_s & ~ck_pq & ck_s;
  assign ck_fall   = ~cs_s & ck_pq & ~ck_s;
  assign byte_w    = {rsh_q, do_s};
  assign byte_done = ck_rise & (bcnt_q == 3'd7);
  assign m_start   = byte_done & ~first_q & ~busy;

`ifdef BRIDGE_STATUS_EN
  logic ovr_q, ovr_d;
  always_ff @(posedge fclk) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end
  // a new overrun beats the clear-on-read
  always_comb begin
    ovr_d = ovr_q;
    if (frm_start) ovr_d = 1'b0;
    if (byte_done && !first_q && busy) ovr_d = 1'b1;
    status = '0;
    status[ST_OVR_BIT]  = ovr_q;
    status[ST_BUSY_BIT] = busy;
  end
`else
  assign status = 8'hFF;
`endif

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      rsh_q   <= '0;
      tsh_q   <= '1;
      spidi_q <= 1'b1;
      first_q <= 1'b1;
      ch_q    <= '0;
      div_q   <= '0;
      cs_n_q  <= '1;
      endp_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      rsh_q   <= rsh_d;
      tsh_q   <= tsh_d;
      spidi_q <= spidi_d;
      first_q <= first_d;
      ch_q    <= ch_d;
      div_q   <= div_d;
      cs_n_q  <= cs_n_d;
      endp_q  <= endp_d;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    rsh_d   = rsh_q;
    first_d = first_q;
    ch_d    = ch_q;
    div_d   = div_q;
    if (ck_rise) begin
      bcnt_d = bcnt_q + 3'd1;
      rsh_d  = byte_w[6:0];
    end
    if (byte_done && first_q) begin
      first_d = 1'b0;
      ch_d    = byte_w[CMD_CH_HI:CMD_CH_LO];
      div_d   = DIV_W'(byte_w[CMD_DIV_HI:CMD_DIV_LO]);
    end
    if (frm_start || frm_end) bcnt_d = '0;
    if (frm_start) first_d = 1'b1;
  end

  // MISO of the next byte is presented on the byte-boundary fall
  always_comb begin
    tsh_d   = tsh_q;
    spidi_d = spidi_q;
    if (ck_fall) spidi_d = tsh_q[3'd7 - bcnt_q];
    if (byte_done) tsh_d = 8'hFF;
    if (m_done) begin
      tsh_d = m_rx;
      if (bcnt_q == 3'd0 && !ck_rise) spidi_d = m_rx[7];
    end
    if (frm_start) begin
      tsh_d   = status;
      spidi_d = status[7];
    end
  end

  always_comb begin
    cs_n_d = cs_n_q;
    endp_d = endp_q;
    if (frm_end) begin
      endp_d = 1'b1;
    end else if (endp_q && !busy) begin
      endp_d = 1'b0;
      cs_n_d = '1;
    end
    if (byte_done && first_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cs_n_d[i] = ~(byte_w[CMD_CS_BIT] &&
                      byte_w[CMD_CH_HI:CMD_CH_LO] == 3'(i));
      end
    end
    if (frm_start) endp_d = 1'b0;
  end

  always_comb begin
    m_miso = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) m_miso = ch_miso[i];
    end
  end

  spi_master_engine #(
    .DIV_W (DIV_W)
  ) u_mst (
    .clk     (fclk),
    .rst_n   (rst_n),
    .start_i (m_start),
    .div_i   (div_q),
    .tx_i    (byte_w),
    .miso_i  (m_miso),
    .busy_o  (busy),
    .done_o  (m_done),
    .rx_o    (m_rx),
    .sck_o   (ch_sck),
    .mosi_o  (ch_mosi)
  );

  assign spidi    = spidi_q;
  assign spiint_n = ~busy;
  assign act      = busy;
  assign ch_cs_n  = cs_n_q;

endmodule
